// File: rtl/ro_pair_sampler.sv
// -----------------------------------------------------------------------------
// ro_pair_sampler
//
// Compares the frequencies of two ring oscillators (RO A and RO B) by gating
// both downstream edge counters for a fixed window, capturing the two counts,
// and voting over several windows. The majority decides the response bit.
//
// Parameters
//   COUNT_WIDTH   width of each incoming RO edge count
//   WINDOW_CYCLES gate cycles per vote (2..65535)
//   NUM_VOTES     measurements per response (odd, 1..15)
//
// Ports
//   clk          single rising-edge clock
//   rst          synchronous active-high reset
//   start        one-cycle request to begin a measurement (IDLE only)
//   ro_enable    registered gate enable to both frequency counters
//   count_a/b    running edge counts of RO A / RO B
//   busy         high in every state except IDLE
//   resp_valid   response available (RESP state)
//   resp_ready   downstream accepts the response
//   resp_bit     1 when A won more votes than B
//   resp_tie     1 when A and B won the same number of votes
//   resp_sat     1 when any captured count was all-ones (sticky per request)
//   resp_diff    |count_a - count_b| of the final vote
// -----------------------------------------------------------------------------
module ro_pair_sampler #(
  parameter int COUNT_WIDTH   = 16,
  parameter int WINDOW_CYCLES = 1024,
  parameter int NUM_VOTES     = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  output logic                   ro_enable,
  input  logic [COUNT_WIDTH-1:0] count_a,
  input  logic [COUNT_WIDTH-1:0] count_b,
  output logic                   busy,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic                   resp_bit,
  output logic                   resp_tie,
  output logic                   resp_sat,
  output logic [COUNT_WIDTH-1:0] resp_diff
);

  localparam int WIN_W  = $clog2(WINDOW_CYCLES + 1);
  localparam int VOTE_W = $clog2(NUM_VOTES + 1);

  localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(WINDOW_CYCLES - 1);
  localparam logic [VOTE_W-1:0] VOTE_LAST = VOTE_W'(NUM_VOTES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GATE,
    ST_CAPTURE,
    ST_RESP
  } state_t;

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic                     r_ro_enable;
  logic [WIN_W-1:0]         r_win;
  logic [VOTE_W-1:0]        r_vote;
  logic [VOTE_W-1:0]        r_a_wins;
  logic [VOTE_W-1:0]        r_b_wins;
  logic                     r_sat;
  logic                     r_bit;
  logic                     r_tie;
  logic [COUNT_WIDTH-1:0]   r_diff;

  logic                     w_a_gt;
  logic                     w_b_gt;
  logic                     w_sat_hit;
  logic [COUNT_WIDTH-1:0]   w_mag;
  logic [VOTE_W-1:0]        w_a_wins_nxt;
  logic [VOTE_W-1:0]        w_b_wins_nxt;

  // Vote arithmetic on the live counts; only consumed in CAPTURE.
  // Larger-minus-smaller keeps the magnitude free of wrap-around.
  assign w_a_gt       = count_a > count_b;
  assign w_b_gt       = count_b > count_a;
  assign w_mag        = w_a_gt ? (count_a - count_b) : (count_b - count_a);
  assign w_sat_hit    = (&count_a) | (&count_b);
  assign w_a_wins_nxt = r_a_wins + VOTE_W'(w_a_gt);
  assign w_b_wins_nxt = r_b_wins + VOTE_W'(w_b_gt);

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path through the case statement can leave it unassigned and infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:    if (start) w_state_nxt = ST_GATE;
      ST_GATE:    if (r_win == WIN_LAST) w_state_nxt = ST_CAPTURE;
      // The single CAPTURE cycle doubles as the counter clear gap between votes.
      ST_CAPTURE: w_state_nxt = (r_vote == VOTE_LAST) ? ST_RESP : ST_GATE;
      ST_RESP:    if (resp_ready) w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_ro_enable <= 1'b0;
      r_win       <= '0;
      r_vote      <= '0;
      r_a_wins    <= '0;
      r_b_wins    <= '0;
      r_sat       <= 1'b0;
      r_bit       <= 1'b0;
      r_tie       <= 1'b0;
      r_diff      <= '0;
    end else begin
      r_state     <= w_state_nxt;
      // Registered gate: high exactly in the cycles the state register says GATE.
      r_ro_enable <= (w_state_nxt == ST_GATE);
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_win    <= '0;
            r_vote   <= '0;
            r_a_wins <= '0;
            r_b_wins <= '0;
            r_sat    <= 1'b0;
          end
        end
        ST_GATE: begin
          r_win <= r_win + WIN_W'(1);
        end
        ST_CAPTURE: begin
          r_win    <= '0;
          if (r_vote != VOTE_LAST) r_vote <= r_vote + VOTE_W'(1);
          r_a_wins <= w_a_wins_nxt;
          r_b_wins <= w_b_wins_nxt;
          r_sat    <= r_sat | w_sat_hit;
          // Result registers are rewritten on every capture, so after the last
          // vote they hold the final decision and stay put through RESP/IDLE.
          r_diff   <= w_mag;
          r_bit    <= (w_a_wins_nxt > w_b_wins_nxt);
          r_tie    <= (w_a_wins_nxt == w_b_wins_nxt);
        end
        default: ;
      endcase
    end
  end

  assign ro_enable  = r_ro_enable;
  assign busy       = (r_state != ST_IDLE);
  assign resp_valid = (r_state == ST_RESP);
  assign resp_bit   = r_bit;
  assign resp_tie   = r_tie;
  assign resp_sat   = r_sat;
  assign resp_diff  = r_diff;

endmodule

// File: tb/tb_ro_pair_sampler.sv
// -----------------------------------------------------------------------------
// tb_ro_pair_sampler
//
// Three instances (NUM_VOTES = 1, 3, 5; WINDOW_CYCLES = 4) share one stimulus
// stream. Each vote's counts are applied for the whole gate window and its
// capture cycle. Expected responses come from a hand-computed table and are
// queued per instance when start is driven; a negedge monitor pops and compares
// them on each handshake and checks first-valid latency.
// -----------------------------------------------------------------------------
module tb_ro_pair_sampler;

  localparam int CW = 16;
  localparam int W  = 4;
  localparam int NI = 3;
  localparam int NV = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          resp_ready;
  logic [CW-1:0] count_a;
  logic [CW-1:0] count_b;

  logic          en    [NI];
  logic          busy  [NI];
  logic          valid [NI];
  logic          rbit  [NI];
  logic          rtie  [NI];
  logic          rsat  [NI];
  logic [CW-1:0] rdiff [NI];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    ro_pair_sampler #(
      .COUNT_WIDTH  (CW),
      .WINDOW_CYCLES(W),
      .NUM_VOTES    (2 * g + 1)
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .ro_enable (en[g]),
      .count_a   (count_a),
      .count_b   (count_b),
      .busy      (busy[g]),
      .resp_valid(valid[g]),
      .resp_ready(resp_ready),
      .resp_bit  (rbit[g]),
      .resp_tie  (rtie[g]),
      .resp_sat  (rsat[g]),
      .resp_diff (rdiff[g])
    );
  end

  typedef struct {
    logic [CW-1:0] a      [5];
    logic [CW-1:0] b      [5];
    bit            e_bit  [NI];
    bit            e_tie  [NI];
    bit            e_sat  [NI];
    logic [CW-1:0] e_diff [NI];
  } vec_t;

  typedef struct {
    bit            b;
    bit            t;
    bit            s;
    logic [CW-1:0] d;
  } resp_t;

  vec_t  vecs [NV];
  resp_t sb_q [NI][$];
  int    n_cmp   = 0;
  int    n_bad   = 0;
  int    cyc     = 0;
  int    t_start = 0;
  bit    prev_valid [NI];

  function automatic int nvotes(input int g);
    return 2 * g + 1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Inputs change and outputs are sampled 2 time units after the rising edge.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor: latency on first valid, payload on each handshake.
  always @(negedge clk) begin
    resp_t e;
    for (int g = 0; g < NI; g++) begin
      if (valid[g] === 1'b1 && !prev_valid[g])
        check($sformatf("latency_v%0d", nvotes(g)), 32'(cyc - t_start),
              32'((W + 1) * nvotes(g) + 1));
      if (valid[g] === 1'b1 && resp_ready === 1'b1) begin
        if (sb_q[g].size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_resp_v%0d: got a response, expected none", nvotes(g));
        end else begin
          e = sb_q[g].pop_front();
          check($sformatf("resp_bit_v%0d",  nvotes(g)), 32'(rbit[g]),  32'(e.b));
          check($sformatf("resp_tie_v%0d",  nvotes(g)), 32'(rtie[g]),  32'(e.t));
          check($sformatf("resp_sat_v%0d",  nvotes(g)), 32'(rsat[g]),  32'(e.s));
          check($sformatf("resp_diff_v%0d", nvotes(g)), 32'(rdiff[g]), 32'(e.d));
        end
      end
      prev_valid[g] = (valid[g] === 1'b1);
    end
  end

  // One full request: queue expectations, pulse start, feed five votes and
  // check the gate, busy and valid waveforms of all instances cycle by cycle.
  // With hold=1 resp_ready is expected low, so every instance parks in RESP.
  task automatic run_txn(input int idx, input bit hold);
    resp_t r;
    int    v;
    for (int g = 0; g < NI; g++) begin
      r.b = vecs[idx].e_bit[g];
      r.t = vecs[idx].e_tie[g];
      r.s = vecs[idx].e_sat[g];
      r.d = vecs[idx].e_diff[g];
      sb_q[g].push_back(r);
    end
    start   = 1'b1;
    t_start = cyc;
    for (int rel = 1; rel <= 27; rel++) begin
      step();
      if (rel == 1) start = 1'b0;
      if (rel <= 21 && (rel - 1) % (W + 1) == 0) begin
        count_a = vecs[idx].a[(rel - 1) / (W + 1)];
        count_b = vecs[idx].b[(rel - 1) / (W + 1)];
      end
      for (int g = 0; g < NI; g++) begin
        v = nvotes(g);
        check($sformatf("ro_enable_v%0d_r%0d", v, rel), 32'(en[g]),
              32'((rel <= (W + 1) * v) && ((rel - 1) % (W + 1) != W)));
        check($sformatf("busy_v%0d_r%0d", v, rel), 32'(busy[g]),
              32'((rel <= (W + 1) * v + 1) || hold));
        check($sformatf("valid_v%0d_r%0d", v, rel), 32'(valid[g]),
              32'((rel == (W + 1) * v + 1) || (hold && rel > (W + 1) * v)));
      end
    end
  endtask

  initial begin
    vecs[0] = '{a: '{10, 10, 10, 10, 10}, b: '{7, 7, 7, 7, 7},
                e_bit: '{1, 1, 1}, e_tie: '{0, 0, 0}, e_sat: '{0, 0, 0},
                e_diff: '{3, 3, 3}};
    vecs[1] = '{a: '{20, 5, 9, 100, 0}, b: '{15, 8, 9, 50, 1},
                e_bit: '{1, 0, 0}, e_tie: '{0, 1, 1}, e_sat: '{0, 0, 0},
                e_diff: '{5, 0, 1}};
    vecs[2] = '{a: '{1, 2, 3, 4, 5}, b: '{0, 16'hFFFF, 1, 9, 0},
                e_bit: '{1, 1, 1}, e_tie: '{0, 0, 0}, e_sat: '{0, 1, 1},
                e_diff: '{1, 2, 5}};
    vecs[3] = '{a: '{1, 16'hFFFE, 16'h8000, 16'h7FFF, 0},
                b: '{16'hFFFE, 1, 16'h7FFF, 16'h8000, 0},
                e_bit: '{0, 1, 0}, e_tie: '{0, 0, 1}, e_sat: '{0, 0, 0},
                e_diff: '{16'hFFFD, 1, 0}};
    vecs[4] = '{a: '{16'hFFFF, 3, 3, 3, 3}, b: '{0, 5, 5, 5, 5},
                e_bit: '{1, 0, 0}, e_tie: '{0, 0, 0}, e_sat: '{1, 1, 1},
                e_diff: '{16'hFFFF, 2, 2}};
    vecs[5] = '{a: '{7, 7, 7, 7, 7}, b: '{7, 7, 7, 7, 7},
                e_bit: '{0, 0, 0}, e_tie: '{1, 1, 1}, e_sat: '{0, 0, 0},
                e_diff: '{0, 0, 0}};

    rst        = 1'b1;
    start      = 1'b0;
    resp_ready = 1'b1;
    count_a    = '0;
    count_b    = '0;
    repeat (3) step();
    rst = 1'b0;

    // Reset state.
    for (int g = 0; g < NI; g++) begin
      check($sformatf("rst_ro_enable_v%0d", nvotes(g)), 32'(en[g]),    32'd0);
      check($sformatf("rst_busy_v%0d",      nvotes(g)), 32'(busy[g]),  32'd0);
      check($sformatf("rst_valid_v%0d",     nvotes(g)), 32'(valid[g]), 32'd0);
      check($sformatf("rst_bit_v%0d",       nvotes(g)), 32'(rbit[g]),  32'd0);
      check($sformatf("rst_tie_v%0d",       nvotes(g)), 32'(rtie[g]),  32'd0);
      check($sformatf("rst_sat_v%0d",       nvotes(g)), 32'(rsat[g]),  32'd0);
      check($sformatf("rst_diff_v%0d",      nvotes(g)), 32'(rdiff[g]), 32'd0);
    end
    step();

    run_txn(0, 1'b0);
    run_txn(1, 1'b0);

    // Reset in the second GATE cycle aborts the request; no response follows.
    start = 1'b1;
    step();
    start   = 1'b0;
    count_a = 16'd50;
    count_b = 16'd40;
    step();
    for (int g = 0; g < NI; g++)
      check($sformatf("abort_gate_en_v%0d", nvotes(g)), 32'(en[g]), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int g = 0; g < NI; g++) begin
      check($sformatf("abort_ro_enable_v%0d", nvotes(g)), 32'(en[g]),    32'd0);
      check($sformatf("abort_busy_v%0d",      nvotes(g)), 32'(busy[g]),  32'd0);
      check($sformatf("abort_valid_v%0d",     nvotes(g)), 32'(valid[g]), 32'd0);
      check($sformatf("abort_diff_v%0d",      nvotes(g)), 32'(rdiff[g]), 32'd0);
    end
    step();
    run_txn(3, 1'b0);

    // Back-pressure: 20 cycles with ready low and start pulsing.
    resp_ready = 1'b0;
    run_txn(2, 1'b1);
    for (int i = 0; i < 20; i++) begin
      step();
      start = (i % 4 == 1);
      for (int g = 0; g < NI; g++) begin
        check($sformatf("hold_valid_v%0d_c%0d", nvotes(g), i), 32'(valid[g]), 32'd1);
        check($sformatf("hold_busy_v%0d_c%0d",  nvotes(g), i), 32'(busy[g]),  32'd1);
        check($sformatf("hold_en_v%0d_c%0d",    nvotes(g), i), 32'(en[g]),    32'd0);
        check($sformatf("hold_bit_v%0d_c%0d",   nvotes(g), i), 32'(rbit[g]),  32'(vecs[2].e_bit[g]));
        check($sformatf("hold_tie_v%0d_c%0d",   nvotes(g), i), 32'(rtie[g]),  32'(vecs[2].e_tie[g]));
        check($sformatf("hold_sat_v%0d_c%0d",   nvotes(g), i), 32'(rsat[g]),  32'(vecs[2].e_sat[g]));
        check($sformatf("hold_diff_v%0d_c%0d",  nvotes(g), i), 32'(rdiff[g]), 32'(vecs[2].e_diff[g]));
      end
    end
    // Handshake cycle with start high: transfer completes, start is ignored.
    resp_ready = 1'b1;
    start      = 1'b1;
    step();
    start = 1'b0;
    for (int g = 0; g < NI; g++) begin
      check($sformatf("post_hs_busy_v%0d",  nvotes(g)), 32'(busy[g]),  32'd0);
      check($sformatf("post_hs_valid_v%0d", nvotes(g)), 32'(valid[g]), 32'd0);
    end
    step();
    for (int g = 0; g < NI; g++) begin
      check($sformatf("no_restart_busy_v%0d", nvotes(g)), 32'(busy[g]), 32'd0);
      check($sformatf("no_restart_en_v%0d",   nvotes(g)), 32'(en[g]),   32'd0);
      // Response outputs keep their values in IDLE.
      check($sformatf("idle_keep_diff_v%0d",  nvotes(g)), 32'(rdiff[g]), 32'(vecs[2].e_diff[g]));
    end

    run_txn(3, 1'b0);
    run_txn(4, 1'b0);
    run_txn(5, 1'b0);
    step();

    for (int g = 0; g < NI; g++)
      check($sformatf("scoreboard_empty_v%0d", nvotes(g)), 32'(sb_q[g].size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
